// File: rtl/pmod_debounce_pkg.sv
// pmod_defs: shared constants and types for the PMOD input-conditioning block.
//   CLK_HZ        system clock frequency
//   DEBOUNCE_10MS stability window of 10 ms, in clock cycles at CLK_HZ
//   PMOD_WIDTH    number of PMOD switch bits conditioned
//   ch_state_e    per-channel debounce state (IDLE: counter at 0, PENDING: counting)
package pmod_defs;

    localparam int CLK_HZ        = 12_000_000;
    localparam int DEBOUNCE_10MS = 120000;
    localparam int PMOD_WIDTH    = 3;

    typedef enum logic {
        CH_IDLE    = 1'b0,
        CH_PENDING = 1'b1
    } ch_state_e;

endpackage

// File: rtl/pmod_debounce_channel.sv
// debounce_channel: one PMOD bit. Two-flop synchroniser, stability counter,
// registered clean level and one-cycle rise/fall pulses.
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   pmod   raw asynchronous pin
//   clean  debounced level
//   rise   one-cycle pulse on clean 0->1
//   fall   one-cycle pulse on clean 1->0
module debounce_channel
    import pmod_defs::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pmod,
    output logic clean,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_s1, r_s2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_clean, r_rise, r_fall;

    ch_state_e        w_state;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_clean_nxt;

    // The counter value itself is the state: zero means nothing pending.
    assign w_state = (r_cnt == '0) ? CH_IDLE : CH_PENDING;

    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_clean_nxt = r_clean;
        case (w_state)
            CH_IDLE: begin
                if (r_s2 != r_clean) begin
                    if (DEBOUNCE_CYCLES == 1) w_clean_nxt = r_s2;
                    else                      w_cnt_nxt   = CNT_W'(1);
                end
            end
            CH_PENDING: begin
                if (r_s2 == r_clean) begin
                    // Pin went back before the window closed: drop the attempt.
                    w_cnt_nxt = '0;
                end else if (r_cnt == LAST) begin
                    w_clean_nxt = r_s2;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: w_cnt_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_cnt   <= '0;
            r_clean <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_s1    <= pmod;
            r_s2    <= r_s1;
            r_cnt   <= w_cnt_nxt;
            r_clean <= w_clean_nxt;
            r_rise  <= w_clean_nxt & ~r_clean;
            r_fall  <= ~w_clean_nxt & r_clean;
        end
    end

    assign clean = r_clean;
    assign rise  = r_rise;
    assign fall  = r_fall;

endmodule

// File: rtl/pmod_debounce.sv
// pmod_debounce: synchronises and debounces WIDTH PMOD switch pins.
// Every bit is an independent debounce_channel with identical latency.
//   clk    system clock (12 MHz)
//   rst_n  asynchronous active-low reset
//   pmod   raw asynchronous switch inputs [WIDTH]
//   clean  debounced levels [WIDTH], flop outputs, safe for combinational use
//   rise   one-cycle pulses on clean 0->1 [WIDTH]
//   fall   one-cycle pulses on clean 1->0 [WIDTH]
module pmod_debounce
    import pmod_defs::*;
#(
    parameter int WIDTH           = PMOD_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pmod,
    output logic [WIDTH-1:0] clean,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .pmod  (pmod[i]),
            .clean (clean[i]),
            .rise  (rise[i]),
            .fall  (fall[i])
        );
    end

endmodule

// File: tb/tb_pmod_debounce.sv
// Scoreboard bench for pmod_debounce with DEBOUNCE_CYCLES=4, WIDTH=3.
// Stimulus pushes the expected edge event (clean/rise/fall and the cycle it
// must appear on); the monitor pops one entry whenever rise or fall is high.
module tb_pmod_debounce;

    localparam int W = 3;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] pmod = '0;
    logic [W-1:0] clean, rise, fall;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] c;
        logic [W-1:0] r;
        logic [W-1:0] f;
        int           at;
    } exp_t;

    exp_t q[$];

    pmod_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pmod  (pmod),
        .clean (clean),
        .rise  (rise),
        .fall  (fall)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every pulse must match the oldest expected event, on its cycle.
    always @(negedge clk) begin
        if ((rise | fall) != '0) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse cyc=%0d clean=%b rise=%b fall=%b", cyc, clean, rise, fall);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (clean !== e.c || rise !== e.r || fall !== e.f || cyc != e.at) begin
                    errors++;
                    $display("FAIL edge_event got cyc=%0d clean=%b rise=%b fall=%b want cyc=%0d clean=%b rise=%b fall=%b",
                             cyc, clean, rise, fall, e.at, e.c, e.r, e.f);
                end
            end
        end
    end

    task automatic push(input logic [W-1:0] c, input logic [W-1:0] r, input logic [W-1:0] f, input int at);
        exp_t e;
        e.c = c; e.r = r; e.f = f; e.at = at;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic wneg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive a value at a negedge; it is captured by s1 on the next posedge E,
    // so the resulting event lands on edge E+N+1 = cyc+N+2.
    task automatic drive_evt(input logic [W-1:0] v, input logic [W-1:0] c,
                             input logic [W-1:0] r, input logic [W-1:0] f);
        pmod = v;
        push(c, r, f, cyc + N + 2);
    endtask

    initial begin
        // Reset with all pins high: outputs held at 0.
        rst_n = 1'b0;
        pmod  = 3'b111;
        wneg(3);
        chk("reset_clean", 32'(clean), 32'h0);
        chk("reset_rise",  32'(rise),  32'h0);
        chk("reset_fall",  32'(fall),  32'h0);
        rst_n = 1'b1;
        push(3'b111, 3'b111, 3'b000, cyc + N + 2);
        wneg(10);
        chk("after_reset_clean", 32'(clean), 32'h7);
        drive_evt(3'b000, 3'b000, 3'b000, 3'b111);
        wneg(10);
        chk("all_low_clean", 32'(clean), 32'h0);

        // Glitch: bit 0 high for 3 cycles only.
        pmod = 3'b001;
        wneg(3);
        pmod = 3'b000;
        wneg(8);
        chk("glitch_clean", 32'(clean), 32'h0);
        chk("glitch_cnt", 32'(dut.g_ch[0].u_ch.r_cnt), 32'h0);

        // Clean press/release on bit 1.
        drive_evt(3'b010, 3'b010, 3'b010, 3'b000);
        wneg(10);
        chk("press1_clean", 32'(clean), 32'h2);
        drive_evt(3'b000, 3'b000, 3'b000, 3'b010);
        wneg(10);
        chk("release1_clean", 32'(clean), 32'h0);

        // Bounce burst on bit 2: 1,0,1,0 then 1 held.
        for (int k = 0; k < 4; k++) begin
            pmod = (k % 2 == 0) ? 3'b100 : 3'b000;
            wneg(1);
        end
        drive_evt(3'b100, 3'b100, 3'b100, 3'b000);
        wneg(10);
        chk("bounce_clean", 32'(clean), 32'h4);
        drive_evt(3'b000, 3'b000, 3'b000, 3'b100);
        wneg(10);

        // Async reset while bit 0 is mid-count.
        pmod = 3'b001;
        wneg(4);
        chk("pending_cnt", 32'(dut.g_ch[0].u_ch.r_cnt), 32'h2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_cnt", 32'(dut.g_ch[0].u_ch.r_cnt), 32'h0);
        chk("async_s2",  32'(dut.g_ch[0].u_ch.r_s2),  32'h0);
        chk("async_clean", 32'(clean), 32'h0);
        wneg(2);
        rst_n = 1'b1;
        push(3'b001, 3'b001, 3'b000, cyc + N + 2);
        wneg(10);
        chk("restart_clean", 32'(clean), 32'h1);
        drive_evt(3'b000, 3'b000, 3'b000, 3'b001);
        wneg(10);

        // Two channels changing on the same edge.
        drive_evt(3'b101, 3'b101, 3'b101, 3'b000);
        wneg(10);
        chk("parallel_clean", 32'(clean), 32'h5);
        drive_evt(3'b000, 3'b000, 3'b000, 3'b101);

        // Bounded drain of outstanding expectations.
        for (int k = 0; k < 20 && q.size() != 0; k++) wneg(1);
        wneg(3);
        while (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_event want cyc=%0d clean=%b rise=%b fall=%b", e.at, e.c, e.r, e.f);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
